// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the CPU pipeline controllers:
// the hazard FSM state encoding, the default register-index width
// and the x0 register index.
package cpu_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } haz_state_e;

  localparam int REG_AW_DEF = 5;

  // Writes to x0 are discarded, so a load to x0 never creates a hazard.
  localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/haz_sat_counter.sv
// Saturating event counter with enable and synchronous active-high reset.
// Holds at all-ones once reached; never wraps back to zero.
module haz_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Count enabled events, sticking at the maximum value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard and sequencing controller.
// Decides each cycle whether PC and IF_ID load, whether IF_ID is flushed
// to a NOP and whether a bubble enters ID_EX. Handles load-use stalls,
// taken-branch flushes lasting FLUSH_CYCLES cycles and memory freezes.
// Outputs are Mealy: combinational from the registered state/count and
// the current inputs.
// Optional build macro HAZ_PERF_CNT_EN adds three saturating performance
// counters (load-use stall cycles, accepted taken branches, memory-freeze
// cycles) of width CNT_W.
module if_id_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_AW       = REG_AW_DEF
`ifdef HAZ_PERF_CNT_EN
  ,parameter int CNT_W       = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memread_i,
  input  logic              branch_taken_i,
  input  logic              mem_stall_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              state_o
`ifdef HAZ_PERF_CNT_EN
  ,output logic [CNT_W-1:0] lu_stall_cnt_o,
  output logic  [CNT_W-1:0] flush_cnt_o,
  output logic  [CNT_W-1:0] mem_freeze_cnt_o
`endif
);

  // Remaining flush cycles after the branch cycle; at most 3 for FLUSH_CYCLES <= 4.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  haz_state_e state_q, state_n;
  logic [2:0] cnt_q, cnt_n;
  logic       lu;
  logic       lu_stall_ev, branch_ev, freeze_ev;

  // Load-use hazard: load in EX writes a register the ID instruction reads.
  always_comb begin
    lu = ex_memread_i && (ex_rd_i != REG_AW'(X0_IDX)) &&
         ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
          (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  end

  // Priority decode of enables and next state (freeze > flush > stall > branch).
  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    lu_stall_ev   = 1'b0;
    branch_ev     = 1'b0;
    freeze_ev     = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (mem_stall_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      freeze_ev    = 1'b1;
    end else if (state_q == FLUSH) begin
      // ID holds a NOP here, so branch and load-use inputs are meaningless.
      ifid_flush_o = 1'b1;
      cnt_n        = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_n = RUN;
    end else if (lu) begin
      // A coincident branch is dropped; it resolves again once the bubble passes.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      lu_stall_ev   = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
      branch_ev    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        cnt_n   = FLUSH_RELOAD;
      end
    end
  end

  // State and flush-count registers; reset aborts any flush in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Debug view of the state; reads RUN throughout reset.
  always_comb begin
    state_o = rst_i ? 1'b0 : logic'(state_q);
  end

`ifdef HAZ_PERF_CNT_EN
  haz_sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (lu_stall_ev),
    .cnt_o (lu_stall_cnt_o)
  );

  haz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (branch_ev),
    .cnt_o (flush_cnt_o)
  );

  haz_sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (freeze_ev),
    .cnt_o (mem_freeze_cnt_o)
  );
`else
  // Event strobes only feed the optional counters.
  logic unused_ev;
  always_comb unused_ev = lu_stall_ev ^ branch_ev ^ freeze_ev;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl with FLUSH_CYCLES = 3.
// Expected enables are pushed when a cycle's stimulus is driven and popped
// when the outputs are sampled on the falling edge.
module tb_if_id_hazard_ctrl;

  localparam int FC = 3;
  localparam int AW = 5;
`ifdef HAZ_PERF_CNT_EN
  localparam int CW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rs1 = '0, rs2 = '0, erd = '0;
  logic          u1 = 1'b0, u2 = 1'b0, mr = 1'b0, br = 1'b0, ms = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, state;
`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0] lu_cnt, fl_cnt, mf_cnt;
  int            m_lu = 0, m_fl = 0, m_mf = 0;
`endif

  always #5 clk = ~clk;

  if_id_hazard_ctrl #(
    .FLUSH_CYCLES (FC),
    .REG_AW       (AW)
`ifdef HAZ_PERF_CNT_EN
    ,.CNT_W       (CW)
`endif
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs1_i       (rs1),
    .id_rs2_i       (rs2),
    .id_use_rs1_i   (u1),
    .id_use_rs2_i   (u2),
    .ex_rd_i        (erd),
    .ex_memread_i   (mr),
    .branch_taken_i (br),
    .mem_stall_i    (ms),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .state_o        (state)
`ifdef HAZ_PERF_CNT_EN
    ,.lu_stall_cnt_o   (lu_cnt),
    .flush_cnt_o       (fl_cnt),
    .mem_freeze_cnt_o  (mf_cnt)
`endif
  );

  typedef struct packed {
    logic pc;
    logic ifw;
    logic fl;
    logic bub;
    logic st;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_st  = 1'b0;
  int   m_cnt = 0;
  logic last_flush;
  logic last_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, sample at negedge, advance the model.
  task automatic step(input logic r, input logic m_r, input logic [AW-1:0] e_rd,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic v1, input logic v2, input logic b, input logic s);
    exp_t e;
    exp_t got_e;
    bit   hz;
    rst = r; mr = m_r; erd = e_rd; rs1 = a1; rs2 = a2;
    u1 = v1; u2 = v2; br = b; ms = s;
    hz = m_r && (e_rd != 0) && ((v1 && a1 == e_rd) || (v2 && a2 == e_rd));
    if (r)         e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    else if (s)    e = '{1'b0, 1'b0, 1'b0, 1'b0, m_st};
    else if (m_st) e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    else if (hz)   e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    else if (b)    e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    else           e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    q.push_back(e);
    @(negedge clk);
    got_e = q.pop_front();
    check("pc_write",    32'(pc_write),    32'(got_e.pc));
    check("ifid_write",  32'(ifid_write),  32'(got_e.ifw));
    check("ifid_flush",  32'(ifid_flush),  32'(got_e.fl));
    check("idex_bubble", 32'(idex_bubble), 32'(got_e.bub));
    check("state",       32'(state),       32'(got_e.st));
    if (!r && ifid_flush) check("flush_implies_write", 32'(ifid_write), 32'd1);
`ifdef HAZ_PERF_CNT_EN
    check("lu_cnt", 32'(lu_cnt), 32'(m_lu));
    check("fl_cnt", 32'(fl_cnt), 32'(m_fl));
    check("mf_cnt", 32'(mf_cnt), 32'(m_mf));
    if (r) begin
      m_lu = 0; m_fl = 0; m_mf = 0;
    end else if (s) begin
      if (m_mf < 15) m_mf++;
    end else if (!m_st && hz) begin
      if (m_lu < 15) m_lu++;
    end else if (!m_st && b) begin
      if (m_fl < 15) m_fl++;
    end
`endif
    last_flush = ifid_flush;
    last_state = state;
    if (r) begin
      m_st = 1'b0; m_cnt = 0;
    end else if (!s) begin
      if (m_st) begin
        if (m_cnt == 1) m_st = 1'b0;
        m_cnt--;
      end else if (!hz && b && FC > 1) begin
        m_st = 1'b1; m_cnt = FC - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int nflush;
    // Reset with random inputs, then first normal cycle.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    idle();
    check("post_reset_pc", 32'(last_flush), 32'd0);

    // Load-use on rs2, then the bubble clears memread.
    step(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    // rd = x0 and unused rs2 must not stall; rs1 match must.
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd7, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    // Branch: exactly FC flush cycles; a second branch inside is ignored.
    nflush = 0;
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    nflush += int'(last_flush);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    nflush += int'(last_flush);
    check("flush_state_c2", 32'(last_state), 32'd1);
    idle();
    nflush += int'(last_flush);
    check("flush_state_c3", 32'(last_state), 32'd1);
    idle();
    nflush += int'(last_flush);
    check("branch_flush_len", 32'(nflush), 32'd3);
    check("after_flush_run", 32'(last_state), 32'd0);

    // Load-use and branch together: stall only.
    step(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("lu_br_noflush", 32'(last_flush), 32'd0);
    idle();

    // Freeze for 4 cycles inside FLUSH with count 2, then finish the flush.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'($urandom), 1'b1);
      check("freeze_state", 32'(last_state), 32'd1);
    end
    nflush = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      nflush += int'(last_flush);
    end
    check("flush_after_freeze", 32'(nflush), 32'd2);

    // Reset in the middle of a flush aborts it.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("reset_abort_flush", 32'(last_flush), 32'd0);

    // 20 load-use stall cycles (counter saturation when counters exist).
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef HAZ_PERF_CNT_EN
    idle();
    check("lu_cnt_sat", 32'(lu_cnt), 32'd15);
    step(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    check("lu_cnt_rst", 32'(lu_cnt), 32'd0);
    check("fl_cnt_rst", 32'(fl_cnt), 32'd0);
    check("mf_cnt_rst", 32'(mf_cnt), 32'd0);
`endif

    // Random traffic with a narrow register range to provoke hazards.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
